// File: rtl/barrier_field_collider_pkg.sv
// Shared types and constants for the barrier field collider.
// Contents: default coordinate width and coordinate type, side-flag bit
// indices, and the scan controller state encoding.
package barrier_field_pkg;

  localparam int COORD_W_DEFAULT = 10;

  typedef logic [COORD_W_DEFAULT-1:0] coord_t;

  localparam int SIDE_LEFT   = 0;
  localparam int SIDE_RIGHT  = 1;
  localparam int SIDE_TOP    = 2;
  localparam int SIDE_BOTTOM = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    SCAN    = 2'd2,
    PUBLISH = 2'd3
  } state_t;

endpackage

// File: rtl/barrier_field_collider_if.sv
// Geometry and result bus for the barrier field collider.
// Object/barrier geometry flows from the master (position and bullet logic)
// into the slave (the collider). Side_Flags, Any_Collision, Barrier_Hit,
// scan_done and busy flow back from the slave.
interface barrier_field_collider_if
  import barrier_field_pkg::*;
#(
  parameter int NUM_BARRIERS = 4,
  parameter int NUM_OBJ      = 4,
  parameter int COORD_W      = COORD_W_DEFAULT
);
  logic [NUM_OBJ*COORD_W-1:0]      Obj_X, Obj_Y, Obj_Size;
  logic [NUM_OBJ-1:0]              Obj_En;
  logic [NUM_BARRIERS*COORD_W-1:0] Barrier_X, Barrier_Y;
  logic [NUM_BARRIERS*COORD_W-1:0] Barrier_Height_Halved, Barrier_Length_Halved;
  logic [NUM_BARRIERS-1:0]         Barrier_En;
  logic [NUM_OBJ*4-1:0]            Side_Flags;
  logic [NUM_OBJ-1:0]              Any_Collision;
  logic [NUM_BARRIERS-1:0]         Barrier_Hit;
  logic                            scan_done;
  logic                            busy;

  modport master (
    output Obj_X, Obj_Y, Obj_Size, Obj_En,
    output Barrier_X, Barrier_Y, Barrier_Height_Halved, Barrier_Length_Halved, Barrier_En,
    input  Side_Flags, Any_Collision, Barrier_Hit, scan_done, busy
  );

  modport slave (
    input  Obj_X, Obj_Y, Obj_Size, Obj_En,
    input  Barrier_X, Barrier_Y, Barrier_Height_Halved, Barrier_Length_Halved, Barrier_En,
    output Side_Flags, Any_Collision, Barrier_Hit, scan_done, busy
  );
endinterface

// File: rtl/barrier_field_collider_box_overlap_side.sv
// Combinational evaluator for one object box against one barrier rectangle.
// Ports: obj_x/obj_y/obj_s (centre and half-size), bar_x/bar_y/bar_h/bar_l
// (centre and half extents in Y and X); overlap (strict), side (one-hot
// {bottom,top,right,left}, zero when not overlapping).
module box_overlap_side
  import barrier_field_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [COORD_W-1:0] obj_s,
  input  logic [COORD_W-1:0] bar_x,
  input  logic [COORD_W-1:0] bar_y,
  input  logic [COORD_W-1:0] bar_h,
  input  logic [COORD_W-1:0] bar_l,
  output logic               overlap,
  output logic [3:0]         side
);
  localparam int W1 = COORD_W + 1;

  logic signed [W1-1:0] dx, dy;
  logic [W1-1:0] adx, ady, sum_x, sum_y, px, py;

  always_comb begin
    dx    = $signed({1'b0, obj_x}) - $signed({1'b0, bar_x});
    dy    = $signed({1'b0, obj_y}) - $signed({1'b0, bar_y});
    adx   = dx[W1-1] ? W1'(-dx) : W1'(dx);
    ady   = dy[W1-1] ? W1'(-dy) : W1'(dy);
    sum_x = {1'b0, bar_l} + {1'b0, obj_s};
    sum_y = {1'b0, bar_h} + {1'b0, obj_s};
    // Penetration depths are only meaningful when overlapping.
    px    = sum_x - adx;
    py    = sum_y - ady;
    overlap = (adx < sum_x) && (ady < sum_y);
    side = '0;
    if (overlap) begin
      // Shallower axis wins; ties resolve horizontally, zero offset counts as right/bottom.
      if (px <= py) begin
        if (dx[W1-1]) side[SIDE_LEFT]  = 1'b1;
        else          side[SIDE_RIGHT] = 1'b1;
      end else begin
        if (dy[W1-1]) side[SIDE_TOP]    = 1'b1;
        else          side[SIDE_BOTTOM] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/barrier_field_collider.sv
// Scans NUM_OBJ object boxes against NUM_BARRIERS barrier rectangles, one
// pair per Clk, after each frame_clk rising edge, and publishes per-object
// side flags, per-object any-hit and per-barrier hit flags.
// Ports: Clk, Reset (async, active high), frame_clk (asynchronous vsync),
// bus (slave side of barrier_field_collider_if).
// Optional macro BARRIER_FIELD_OVERRUN_CNT_EN adds overrun_cnt[7:0], a
// saturating count of frame edges dropped while a rescan was already pending.
//
// state   | meaning
// IDLE    | waiting for a frame edge
// LATCH   | snapshot inputs, clear shadow results
// SCAN    | evaluate one object/barrier pair per cycle, barrier-major
// PUBLISH | copy results out, pulse scan_done, rescan if pending
module barrier_field_collider
  import barrier_field_pkg::*;
#(
  parameter int NUM_BARRIERS = 4,
  parameter int NUM_OBJ      = 4,
  parameter int COORD_W      = COORD_W_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  barrier_field_collider_if.slave bus
`ifdef BARRIER_FIELD_OVERRUN_CNT_EN
  , output logic [7:0] overrun_cnt
`endif
);
  localparam int NP   = NUM_BARRIERS * NUM_OBJ;
  localparam int PW   = $clog2(NP + 1);
  localparam int OB_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int BB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam logic [OB_W-1:0] OBJ_LAST = OB_W'(NUM_OBJ - 1);

  state_t state, state_nxt;
  logic   pending, pending_nxt;
  logic [2:0] sync_q;
  logic   frame_edge;

  logic [NUM_OBJ*COORD_W-1:0]      obj_x_q, obj_y_q, obj_s_q;
  logic [NUM_OBJ-1:0]              obj_en_q;
  logic [NUM_BARRIERS*COORD_W-1:0] bar_x_q, bar_y_q, bar_h_q, bar_l_q;
  logic [NUM_BARRIERS-1:0]         bar_en_q;

  logic [OB_W-1:0] obj_idx;
  logic [BB_W-1:0] bar_idx;
  logic [PW-1:0]   pairs_left;
  logic            last_pair;

  logic [NUM_OBJ*4-1:0]    shadow_side, side_nxt, out_side;
  logic [NUM_BARRIERS-1:0] shadow_hit, hit_nxt, out_hit;

  logic       pair_overlap, pair_hit;
  logic [3:0] pair_side;

  assign frame_edge = sync_q[1] & ~sync_q[2];
  assign last_pair  = (pairs_left == PW'(1));

  box_overlap_side #(.COORD_W(COORD_W)) u_pair (
    .obj_x   (obj_x_q[obj_idx*COORD_W +: COORD_W]),
    .obj_y   (obj_y_q[obj_idx*COORD_W +: COORD_W]),
    .obj_s   (obj_s_q[obj_idx*COORD_W +: COORD_W]),
    .bar_x   (bar_x_q[bar_idx*COORD_W +: COORD_W]),
    .bar_y   (bar_y_q[bar_idx*COORD_W +: COORD_W]),
    .bar_h   (bar_h_q[bar_idx*COORD_W +: COORD_W]),
    .bar_l   (bar_l_q[bar_idx*COORD_W +: COORD_W]),
    .overlap (pair_overlap),
    .side    (pair_side)
  );

  assign pair_hit = pair_overlap & obj_en_q[obj_idx] & bar_en_q[bar_idx];

  always_comb begin
    side_nxt = shadow_side;
    hit_nxt  = shadow_hit;
    if (pair_hit) begin
      side_nxt[obj_idx*4 +: 4] = shadow_side[obj_idx*4 +: 4] | pair_side;
      hit_nxt[bar_idx]         = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE:    if (frame_edge) state_nxt = LATCH;
      LATCH: begin
        state_nxt = SCAN;
        if (frame_edge) pending_nxt = 1'b1;
      end
      SCAN: begin
        if (last_pair) state_nxt = PUBLISH;
        if (frame_edge) pending_nxt = 1'b1;
      end
      PUBLISH: begin
        // An edge landing in PUBLISH itself is folded into the immediate rescan.
        state_nxt   = (pending || frame_edge) ? LATCH : IDLE;
        pending_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      sync_q      <= '0;
      obj_x_q     <= '0;
      obj_y_q     <= '0;
      obj_s_q     <= '0;
      obj_en_q    <= '0;
      bar_x_q     <= '0;
      bar_y_q     <= '0;
      bar_h_q     <= '0;
      bar_l_q     <= '0;
      bar_en_q    <= '0;
      obj_idx     <= '0;
      bar_idx     <= '0;
      pairs_left  <= '0;
      shadow_side <= '0;
      shadow_hit  <= '0;
      out_side    <= '0;
      out_hit     <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      sync_q  <= {sync_q[1:0], frame_clk};
      case (state)
        LATCH: begin
          obj_x_q     <= bus.Obj_X;
          obj_y_q     <= bus.Obj_Y;
          obj_s_q     <= bus.Obj_Size;
          obj_en_q    <= bus.Obj_En;
          bar_x_q     <= bus.Barrier_X;
          bar_y_q     <= bus.Barrier_Y;
          bar_h_q     <= bus.Barrier_Height_Halved;
          bar_l_q     <= bus.Barrier_Length_Halved;
          bar_en_q    <= bus.Barrier_En;
          obj_idx     <= '0;
          bar_idx     <= '0;
          pairs_left  <= PW'(NP);
          shadow_side <= '0;
          shadow_hit  <= '0;
        end
        SCAN: begin
          shadow_side <= side_nxt;
          shadow_hit  <= hit_nxt;
          pairs_left  <= pairs_left - 1'b1;
          if (obj_idx == OBJ_LAST) begin
            obj_idx <= '0;
            bar_idx <= bar_idx + 1'b1;
          end else begin
            obj_idx <= obj_idx + 1'b1;
          end
          // Outputs load together with the final pair so they are valid during PUBLISH.
          if (last_pair) begin
            out_side <= side_nxt;
            out_hit  <= hit_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BARRIER_FIELD_OVERRUN_CNT_EN
  // pending is never set in IDLE, so this covers every dropped edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      overrun_cnt <= '0;
    else if (frame_edge && pending && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBJ; gi++) begin : g_any
      assign bus.Any_Collision[gi] = |out_side[gi*4 +: 4];
    end
  endgenerate

  assign bus.Side_Flags  = out_side;
  assign bus.Barrier_Hit = out_hit;
  assign bus.scan_done   = (state == PUBLISH);
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_barrier_field_collider.sv
module tb_barrier_field_collider;
  localparam int NB = 2;
  localparam int NO = 4;
  localparam int CW = 10;

  logic Clk = 1'b0;
  logic Reset;
  logic frame_clk;
`ifdef BARRIER_FIELD_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  barrier_field_collider_if #(.NUM_BARRIERS(NB), .NUM_OBJ(NO), .COORD_W(CW)) bus ();

  barrier_field_collider #(.NUM_BARRIERS(NB), .NUM_OBJ(NO), .COORD_W(CW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
`ifdef BARRIER_FIELD_OVERRUN_CNT_EN
    , .overrun_cnt (overrun_cnt)
`endif
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] sf;
    logic [3:0]  ac;
    logic [1:0]  bh;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: compares each published result against the queue head.
  always @(negedge Clk) begin
    if (!Reset && bus.scan_done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_scan_done got=1 want=0");
      end else begin
        e = exp_q.pop_front();
        chk("side_flags", 32'(bus.Side_Flags), 32'(e.sf));
        chk("any_collision", 32'(bus.Any_Collision), 32'(e.ac));
        chk("barrier_hit", 32'(bus.Barrier_Hit), 32'(e.bh));
      end
    end
  end

  task automatic set_obj(input int i, input int x, input int y);
    bus.Obj_X[i*CW +: CW] = CW'(x);
    bus.Obj_Y[i*CW +: CW] = CW'(y);
  endtask

  task automatic park_all();
    for (int i = 0; i < NO; i++) set_obj(i, 900, 900);
  endtask

  task automatic push(input logic [15:0] sf, input logic [3:0] ac, input logic [1:0] bh);
    exp_t e;
    e.sf = sf; e.ac = ac; e.bh = bh;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input int hi, input int lo);
    frame_clk = 1'b1;
    repeat (hi) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (lo) @(negedge Clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 80) begin
      @(negedge Clk);
      n++;
    end
    if (exp_q.size() != 0 || bus.busy) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout got_pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic run_vec(input logic [15:0] sf, input logic [3:0] ac, input logic [1:0] bh);
    push(sf, ac, bh);
    pulse(2, 2);
    drain();
  endtask

  initial begin
    int n, bc, sd_at, d0;
    Reset = 1'b1;
    frame_clk = 1'b0;
    bus.Barrier_X             = {10'd400, 10'd300};
    bus.Barrier_Y             = {10'd140, 10'd200};
    bus.Barrier_Height_Halved = {10'd30, 10'd15};
    bus.Barrier_Length_Halved = {10'd20, 10'd60};
    bus.Barrier_En            = 2'b11;
    bus.Obj_Size              = {4{10'd4}};
    bus.Obj_En                = 4'b1111;
    park_all();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_side_flags", 32'(bus.Side_Flags), 0);
    chk("reset_barrier_hit", 32'(bus.Barrier_Hit), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_scan_done", 32'(bus.scan_done), 0);

    // Directed vectors
    set_obj(0, 237, 200);                 run_vec(16'h0001, 4'b0001, 2'b01);
    set_obj(0, 236, 200);                 run_vec(16'h0000, 4'b0000, 2'b00);
    park_all(); set_obj(2, 300, 184);     run_vec(16'h0400, 4'b0100, 2'b01);
    park_all(); set_obj(1, 378, 108);     run_vec(16'h0010, 4'b0010, 2'b10);
    bus.Obj_En = 4'b1101;                 run_vec(16'h0000, 4'b0000, 2'b00);
    bus.Obj_En = 4'b1111;
    set_obj(0, 237, 200); set_obj(1, 378, 108); set_obj(2, 300, 184); set_obj(3, 400, 140);
    run_vec(16'h2411, 4'b1111, 2'b11);
    park_all(); set_obj(0, 300, 210);     run_vec(16'h0008, 4'b0001, 2'b01);
    set_obj(0, 237, 200); bus.Barrier_En = 2'b10;
    run_vec(16'h0000, 4'b0000, 2'b00);
    bus.Barrier_En = 2'b11;
    bus.Barrier_Length_Halved = {10'd20, 10'd100};
    set_obj(0, 236, 200);                 run_vec(16'h0008, 4'b0001, 2'b01);
    bus.Barrier_Length_Halved = {10'd20, 10'd60};

    // Single-edge timing: busy spans LATCH..PUBLISH, scan_done on its last cycle
    set_obj(0, 237, 200);
    push(16'h0001, 4'b0001, 2'b01);
    frame_clk = 1'b1;
    n = 0;
    while (!bus.busy && n < 20) begin @(negedge Clk); n++; end
    bc = 0; sd_at = 0;
    while (bus.busy && bc < 40) begin
      bc++;
      if (bus.scan_done) sd_at = bc;
      @(negedge Clk);
    end
    chk("busy_cycles", bc, 10);
    chk("scan_done_cycle", sd_at, 10);
    frame_clk = 1'b0;
    drain();

    // Second edge mid-scan gives a rescan, third edge while pending is dropped
    set_obj(2, 300, 184);
    d0 = done_cnt;
    push(16'h0401, 4'b0101, 2'b01);
    push(16'h0401, 4'b0101, 2'b01);
    pulse(2, 2); pulse(2, 2); pulse(2, 2);
    drain();
    repeat (10) @(negedge Clk);
    chk("rescan_count", done_cnt - d0, 2);
`ifdef BARRIER_FIELD_OVERRUN_CNT_EN
    chk("overrun_cnt", 32'(overrun_cnt), 1);
`endif

    // Reset mid-scan aborts with outputs cleared and no scan_done
    pulse(2, 2);
    repeat (2) @(negedge Clk);
    chk("abort_in_scan_busy", 32'(bus.busy), 1);
    Reset = 1'b1;
    #1;
    chk("abort_side_flags", 32'(bus.Side_Flags), 0);
    chk("abort_any", 32'(bus.Any_Collision), 0);
    chk("abort_barrier_hit", 32'(bus.Barrier_Hit), 0);
    chk("abort_busy", 32'(bus.busy), 0);
`ifdef BARRIER_FIELD_OVERRUN_CNT_EN
    chk("abort_overrun_cnt", 32'(overrun_cnt), 0);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge Clk);
    chk("no_done_after_abort", done_cnt - d0, 0);
    run_vec(16'h0401, 4'b0101, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
